// File: rtl/jesd204_fec_encode_mlane.sv
// Multi-lane JESD204C (2074,2048) FEC parity generator with multiblock framing check.
// Optional `JESD204_FEC_ERR_INJECT_EN adds err_inject_mask, XORed into fec_out at the latch.
module jesd204_fec_encode_mlane #(
    parameter int unsigned NUM_LANES  = 1,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_in_valid,
    input  logic                          eomb,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
`ifdef JESD204_FEC_ERR_INJECT_EN
    input  logic [NUM_LANES*26-1:0]       err_inject_mask,
`endif
    output logic [NUM_LANES*26-1:0]       fec_out,
    output logic                          fec_valid,
    output logic                          align_error
);

    localparam int unsigned MB_BEATS = 2048 / DATA_WIDTH;
    localparam int unsigned CW       = (MB_BEATS > 1) ? $clog2(MB_BEATS) : 1;
    localparam logic [25:0] POLY     = 26'h0220211;
    localparam logic [CW-1:0] LAST   = CW'(MB_BEATS - 1);

    // data[0] is the earliest (highest-degree) bit of the beat
    function automatic logic [25:0] lfsr_step(input logic [25:0] r_in,
                                              input logic [DATA_WIDTH-1:0] d);
        logic [25:0] r;
        logic        fb;
        r = r_in;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            fb = d[i] ^ r[25];
            r  = {r[24:0], 1'b0} ^ ({26{fb}} & POLY);
        end
        return r;
    endfunction

    logic [CW-1:0]          count;
    logic [25:0]            rem      [NUM_LANES];
    logic [25:0]            rem_next [NUM_LANES];
    logic [NUM_LANES*26-1:0] fec_next;
    logic                   at_last;
    logic                   good_end;
    logic                   frame_err;
    logic                   frame_end;

    assign at_last   = (count == LAST);
    assign good_end  = data_in_valid & eomb & at_last;
    assign frame_err = data_in_valid & (eomb ^ at_last);
    assign frame_end = data_in_valid & (eomb | at_last);

    always_comb begin
        fec_next = '0;
        for (int unsigned n = 0; n < NUM_LANES; n++) begin
            rem_next[n] = lane_en[n] ? lfsr_step(rem[n], data_in[n*DATA_WIDTH +: DATA_WIDTH]) : '0;
            fec_next[n*26 +: 26] = rem_next[n];
        end
`ifdef JESD204_FEC_ERR_INJECT_EN
        fec_next = fec_next ^ err_inject_mask;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            fec_out     <= '0;
            fec_valid   <= 1'b0;
            align_error <= 1'b0;
            for (int unsigned n = 0; n < NUM_LANES; n++) begin
                rem[n] <= '0;
            end
        end else begin
            fec_valid   <= good_end;
            align_error <= frame_err;
            if (good_end) begin
                fec_out <= fec_next;
            end
            if (data_in_valid) begin
                count <= frame_end ? '0 : count + 1'b1;
            end
            // any frame end (good or violating) restarts every lane at a clean boundary
            for (int unsigned n = 0; n < NUM_LANES; n++) begin
                if (!lane_en[n] || frame_end) begin
                    rem[n] <= '0;
                end else if (data_in_valid) begin
                    rem[n] <= rem_next[n];
                end
            end
        end
    end

endmodule

// File: tb/tb_jesd204_fec_encode_mlane.sv
// Scoreboard bench for jesd204_fec_encode_mlane: random beats, long-division parity reference.
module tb_jesd204_fec_encode_mlane;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned MB = 2048 / DW;

    typedef struct {
        int unsigned         due;
        bit                  is_fec;
        logic [NL*26-1:0]    val;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               data_in_valid = 1'b0;
    logic               eomb = 1'b0;
    logic [NL-1:0]      lane_en = '1;
    logic [NL*DW-1:0]   data_in = '0;
    logic [NL*26-1:0]   mask = '0;
    logic [NL*26-1:0]   fec_out;
    logic               fec_valid;
    logic               align_error;

    int unsigned        cyc = 0;
    int unsigned        compared = 0;
    int unsigned        mismatched = 0;
    exp_t               q[$];

    logic [2047:0]      mbits [NL];
    int unsigned        mlen  [NL];
    int unsigned        mcount = 0;
    logic [NL*26-1:0]   last_fec = '0;
    logic [NL*DW-1:0]   beats [MB];
    logic [NL*26-1:0]   saved;

    jesd204_fec_encode_mlane #(
        .NUM_LANES (NL),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_valid  (data_in_valid),
        .eomb           (eomb),
        .lane_en        (lane_en),
        .data_in        (data_in),
`ifdef JESD204_FEC_ERR_INJECT_EN
        .err_inject_mask(mask),
`endif
        .fec_out        (fec_out),
        .fec_valid      (fec_valid),
        .align_error    (align_error)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // (m(x) * x^26) mod g(x) by polynomial long division; bit k of the stream has degree len-1-k
    function automatic logic [25:0] ref_parity(input logic [2047:0] bits, input int unsigned len);
        logic [2073:0] p;
        logic [26:0]   g;
        g = 27'h4220211;
        p = '0;
        for (int unsigned k = 0; k < len; k++) p[len - 1 - k + 26] = bits[k];
        for (int d = int'(len) + 25; d >= 26; d--) begin
            if (p[d]) begin
                for (int j = 0; j <= 26; j++) begin
                    if (g[j]) p[d - 26 + j] = ~p[d - 26 + j];
                end
            end
        end
        return p[25:0];
    endfunction

    function automatic logic [NL*DW-1:0] rand_data();
        logic [NL*DW-1:0] r;
        for (int unsigned i = 0; i < NL*DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        mcount = 0;
        for (int unsigned n = 0; n < NL; n++) mlen[n] = 0;
    endtask

    task automatic send_beat(input logic [NL*DW-1:0] d, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        data_in       = d;
        eomb          = e;
        data_in_valid = 1'b1;
        for (int unsigned n = 0; n < NL; n++) begin
            if (lane_en[n]) begin
                for (int unsigned i = 0; i < DW; i++) mbits[n][mlen[n] + i] = d[n*DW + i];
                mlen[n] += DW;
            end else begin
                mlen[n] = 0;
            end
        end
        if (e || mcount == MB - 1) begin
            x.due = cyc + 1;
            if (e && mcount == MB - 1) begin
                x.is_fec = 1'b1;
                for (int unsigned n = 0; n < NL; n++)
                    x.val[n*26 +: 26] = lane_en[n] ? ref_parity(mbits[n], mlen[n]) : 26'h0;
                x.val    = x.val ^ mask;
                last_fec = x.val;
            end else begin
                x.is_fec = 1'b0;
                x.val    = last_fec;
            end
            q.push_back(x);
            model_clear();
        end else begin
            mcount++;
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            data_in_valid = 1'b0;
            eomb          = 1'b0;
            data_in       = rand_data();
        end
    endtask

    task automatic random_mb();
        for (int unsigned b = 0; b < MB; b++) send_beat(rand_data(), b == MB - 1);
    endtask

    task automatic zero_mb();
        for (int unsigned b = 0; b < MB; b++) send_beat('0, b == MB - 1);
    endtask

    task automatic check(input string name, input logic [NL*26-1:0] got, input logic [NL*26-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard, including its cycle
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (fec_valid || align_error) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: fec_valid=%0b align_error=%0b at cycle %0d, required no pulse",
                         fec_valid, align_error, cyc);
            end else begin
                e = q.pop_front();
                if (e.due != cyc || e.is_fec != fec_valid || e.is_fec == align_error || e.val !== fec_out) begin
                    mismatched++;
                    $display("FAIL %s: got cycle %0d fec_valid=%0b align_error=%0b fec_out=%h, required cycle %0d fec_valid=%0b align_error=%0b fec_out=%h",
                             e.is_fec ? "parity_pulse" : "align_pulse", cyc, fec_valid, align_error, fec_out,
                             e.due, e.is_fec, !e.is_fec, e.val);
                end
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_fec_out", fec_out, '0);
        check("reset_fec_valid", {{(NL*26-1){1'b0}}, fec_valid}, '0);
        check("reset_align_error", {{(NL*26-1){1'b0}}, align_error}, '0);

        lane_en = '1;
        zero_mb();
        idle(3);
        check("all_zero_mb", fec_out, '0);

        for (int unsigned b = 0; b < MB; b++) begin
            logic [NL*DW-1:0] d;
            d = '0;
            if (b == MB - 1) d[DW-1] = 1'b1;
            send_beat(d, b == MB - 1);
        end
        idle(3);
        check("single_one_last", {{(NL*26-26){1'b0}}, fec_out[25:0]}, {{(NL*26-26){1'b0}}, 26'h0220211});

        lane_en = 4'b1011;
        for (int unsigned b = 0; b < MB; b++) begin
            logic [NL*DW-1:0] d;
            d = rand_data();
            d[2*DW +: DW] = d[0 +: DW];
            send_beat(d, b == MB - 1);
        end
        idle(3);
        check("disabled_lane2", {{(NL*26-26){1'b0}}, fec_out[2*26 +: 26]}, '0);
        lane_en = '1;

        for (int unsigned b = 0; b <= 20; b++) send_beat(rand_data(), b == 20);
        random_mb();
        idle(2);

        for (int unsigned b = 0; b < MB; b++) send_beat(rand_data(), 1'b0);
        random_mb();
        idle(2);

        for (int unsigned b = 0; b < MB; b++) beats[b] = rand_data();
        for (int unsigned b = 0; b < MB; b++) send_beat(beats[b], b == MB - 1);
        idle(3);
        saved = fec_out;
        for (int unsigned b = 0; b < MB; b++) begin
            while ($urandom_range(1, 0) == 1) idle(1);
            send_beat(beats[b], b == MB - 1);
        end
        idle(3);
        check("gapped_equals_ungapped", fec_out, saved);

        for (int unsigned b = 0; b < 10; b++) send_beat(rand_data(), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        data_in_valid = 1'b0;
        eomb = 1'b0;
        model_clear();
        last_fec = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("midmb_reset_fec_out", fec_out, '0);
        check("midmb_reset_fec_valid", {{(NL*26-1){1'b0}}, fec_valid}, '0);
        check("midmb_reset_align_error", {{(NL*26-1){1'b0}}, align_error}, '0);

        random_mb();
        random_mb();
        random_mb();
        idle(2);

`ifdef JESD204_FEC_ERR_INJECT_EN
        mask = '0;
        mask[25:0] = 26'h2000000;
        zero_mb();
        idle(3);
        check("inject_mask", {{(NL*26-26){1'b0}}, fec_out[25:0]}, {{(NL*26-26){1'b0}}, 26'h2000000});
        mask = '0;
        zero_mb();
        idle(3);
        check("inject_cleared", fec_out, '0);
`endif

        idle(5);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d outstanding pulses, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
